// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, instruction
// width and MIPS field bit positions.
package instr_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicing of a MIPS instruction word into its decode fields.
module instr_field_split
  import instr_fetch_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [5:0]         opcode_o,
  output logic [4:0]         rs_o,
  output logic [4:0]         rt_o,
  output logic [4:0]         rd_o,
  output logic [4:0]         shamt_o,
  output logic [5:0]         funct_o,
  output logic [15:0]        imm16_o,
  output logic [25:0]        jaddr_o
);

  assign opcode_o = instr_i[INSTR_W-1:OPCODE_LSB];
  assign rs_o     = instr_i[OPCODE_LSB-1:RS_LSB];
  assign rt_o     = instr_i[RS_LSB-1:RT_LSB];
  assign rd_o     = instr_i[RT_LSB-1:RD_LSB];
  assign shamt_o  = instr_i[RD_LSB-1:SHAMT_LSB];
  assign funct_o  = instr_i[SHAMT_LSB-1:0];
  assign imm16_o  = instr_i[RT_LSB-1:0];
  assign jaddr_o  = instr_i[OPCODE_LSB-1:0];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, req/ack instruction memory handshake, instruction
// register and branch/jump redirect handling.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         pend_q, pend_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  redirect_tgt;

  assign redirect_tgt = redirect_pc & ~32'h3;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mem_req_d = mem_req_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    pc_out_d  = pc_out_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    unique case (state_q)
      StIdle: begin
        state_d   = StReq;
        mem_req_d = 1'b1;
      end
      StReq: begin
        if (mem_ack) begin
          // An outstanding request always completes; a redirect only decides
          // whether its data is kept.
          if (redirect) begin
            pc_d   = redirect_tgt;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = tgt_q;
            pend_d = 1'b0;
          end else begin
            instr_d   = mem_data;
            pc_out_d  = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 32'd4;
            mem_req_d = 1'b0;
            state_d   = StHold;
          end
        end else if (redirect) begin
          pend_d = 1'b1;
          tgt_d  = redirect_tgt;
        end
      end
      StHold: begin
        if (stall) begin
          if (redirect) begin
            pend_d = 1'b1;
            tgt_d  = redirect_tgt;
          end
        end else begin
          valid_d   = 1'b0;
          instr_d   = NOP_WORD;
          state_d   = StReq;
          mem_req_d = 1'b1;
          pend_d    = 1'b0;
          if (redirect) begin
            pc_d = redirect_tgt;
          end else if (pend_q) begin
            pc_d = tgt_q;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      mem_req_q <= 1'b0;
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
      pc_out_q  <= RESET_PC;
      pend_q    <= 1'b0;
      tgt_q     <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mem_req_q <= mem_req_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      pc_out_q  <= pc_out_d;
      pend_q    <= pend_d;
      tgt_q     <= tgt_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign pc_plus4    = pc_out_q + 32'd4;

  instr_field_split u_split (
    .instr_i  (instr_q),
    .opcode_o (opcode),
    .rs_o     (rs),
    .rt_o     (rt),
    .rd_o     (rd),
    .shamt_o  (shamt),
    .funct_o  (funct),
    .imm16_o  (imm16),
    .jaddr_o  (jaddr)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected captures, a
// monitor pops them on each rising instr_valid.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req, mem_ack, stall, redirect, instr_valid;
  logic [31:0] mem_addr, mem_data, redirect_pc, instr, pc_out, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;

  logic        mem_req_b, mem_ack_b, instr_valid_b;
  logic [31:0] mem_addr_b, mem_data_b, instr_b, pc_out_b, pc_plus4_b;
  logic [5:0]  opcode_b, funct_b;
  logic [4:0]  rs_b, rt_b, rd_b, shamt_b;
  logic [15:0] imm16_b;
  logic [25:0] jaddr_b;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut_a (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16), .jaddr(jaddr)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0000_0000)) dut_b (
    .clock(clock), .reset(reset), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_ack(mem_ack_b), .mem_data(mem_data_b), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .instr_valid(instr_valid_b), .instr(instr_b),
    .pc_out(pc_out_b), .pc_plus4(pc_plus4_b), .opcode(opcode_b), .rs(rs_b), .rt(rt_b),
    .rd(rd_b), .shamt(shamt_b), .funct(funct_b), .imm16(imm16_b), .jaddr(jaddr_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Waits (bounded) at negedges until dut_a raises mem_req, then checks the address.
  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("req_seen", 32'(mem_req), 32'h1);
    chk("req_addr", mem_addr, a);
  endtask

  // Serves one request after `waits` idle cycles; `keep` says the word must be captured.
  task automatic serve(input logic [31:0] a, input logic [31:0] d, input int waits,
                       input bit keep);
    exp_t e;
    wait_req(a);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req_held", 32'(mem_req), 32'h1);
      chk("wait_addr_held", mem_addr, a);
      chk("wait_valid_low", 32'(instr_valid), 32'h0);
      @(negedge clock);
    end
    mem_ack  = 1'b1;
    mem_data = d;
    if (keep) begin
      e.pc   = a;
      e.word = d;
      sb_q.push_back(e);
    end
    @(negedge clock);
    mem_ack  = 1'b0;
    mem_data = 32'h0;
  endtask

  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (instr_valid === 1'b1 && !prev_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid_pc", pc_out, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("mon_instr", instr, e.word);
          chk("mon_pc_out", pc_out, e.pc);
          chk("mon_pc_plus4", pc_plus4, e.pc + 32'd4);
          chk("mon_opcode", 32'(opcode), 32'(e.word[31:26]));
          chk("mon_rs", 32'(rs), 32'(e.word[25:21]));
          chk("mon_rt", 32'(rt), 32'(e.word[20:16]));
          chk("mon_rd", 32'(rd), 32'(e.word[15:11]));
          chk("mon_shamt", 32'(shamt), 32'(e.word[10:6]));
          chk("mon_funct", 32'(funct), 32'(e.word[5:0]));
          chk("mon_imm16", 32'(imm16), 32'(e.word[15:0]));
          chk("mon_jaddr", 32'(jaddr), 32'(e.word[25:0]));
        end
      end
      prev_valid = (instr_valid === 1'b1);
    end
  end

  initial begin : stimulus
    reset = 1'b1; mem_ack = 1'b0; mem_data = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; mem_ack_b = 1'b0; mem_data_b = 32'h0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    chk("rst_b_mem_addr", mem_addr_b, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Wraparound instance: fetch at 0xFFFFFFFC, next PC wraps to 0.
    @(negedge clock);
    chk("b_req", 32'(mem_req_b), 32'h1);
    chk("b_addr", mem_addr_b, 32'hFFFF_FFFC);
    mem_ack_b = 1'b1; mem_data_b = 32'h2401_0001;
    @(negedge clock);
    mem_ack_b = 1'b0;
    chk("b_valid", 32'(instr_valid_b), 32'h1);
    chk("b_instr", instr_b, 32'h2401_0001);
    chk("b_pc_out", pc_out_b, 32'hFFFF_FFFC);
    chk("b_pc_plus4", pc_plus4_b, 32'h0000_0000);
    @(negedge clock);
    chk("b_next_req", 32'(mem_req_b), 32'h1);
    chk("b_next_addr", mem_addr_b, 32'h0000_0000);

    // Zero-wait fetch of addi $8,$0,7.
    serve(32'h0, 32'h2008_0007, 0, 1'b1);
    chk("v0_valid", 32'(instr_valid), 32'h1);
    chk("v0_opcode", 32'(opcode), 32'h08);
    chk("v0_rs", 32'(rs), 32'h0);
    chk("v0_rt", 32'(rt), 32'h8);
    chk("v0_imm16", 32'(imm16), 32'h0007);
    chk("v0_pc_plus4", pc_plus4, 32'h4);

    // Three wait states at 0x4, then a 4-cycle stall in HOLD.
    serve(32'h4, 32'h8C22_0010, 3, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("stall_instr", instr, 32'h8C22_0010);
      chk("stall_pc_out", pc_out, 32'h4);
      chk("stall_mem_req", 32'(mem_req), 32'h0);
      chk("stall_valid", 32'(instr_valid), 32'h1);
    end
    stall = 1'b0;
    @(negedge clock);
    chk("release_req", 32'(mem_req), 32'h1);
    chk("release_addr", mem_addr, 32'h8);

    // Redirect to 0x103 while the request at 0x8 is outstanding.
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clock);
    redirect = 1'b0;
    serve(32'h8, 32'hDEAD_BEEF, 1, 1'b0);
    chk("discard_valid", 32'(instr_valid), 32'h0);
    chk("discard_addr", mem_addr, 32'h0000_0100);
    serve(32'h100, 32'h012A_4020, 0, 1'b1);

    // Redirect coinciding with ack at 0x104.
    wait_req(32'h104);
    mem_ack = 1'b1; mem_data = 32'h1111_1111; redirect = 1'b1; redirect_pc = 32'h0000_0201;
    @(negedge clock);
    mem_ack = 1'b0; redirect = 1'b0;
    chk("coinc_valid", 32'(instr_valid), 32'h0);
    chk("coinc_addr", mem_addr, 32'h0000_0200);
    serve(32'h200, 32'h0800_0040, 0, 1'b1);

    // Redirect while stalled in HOLD takes effect at release.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_030A;
    @(negedge clock);
    redirect = 1'b0;
    chk("hstall_pc_out", pc_out, 32'h200);
    chk("hstall_req", 32'(mem_req), 32'h0);
    @(negedge clock);
    chk("hstall_valid", 32'(instr_valid), 32'h1);
    stall = 1'b0;
    @(negedge clock);
    chk("hrel_req", 32'(mem_req), 32'h1);
    chk("hrel_addr", mem_addr, 32'h0000_0308);
    serve(32'h308, 32'h3C01_ABCD, 0, 1'b1);

    // Reset while the request at 0x30C waits.
    wait_req(32'h30C);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("arst_req", 32'(mem_req), 32'h0);
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    serve(32'h0, 32'h2008_0007, 0, 1'b1);

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage of the single-cycle MIPS datapath. Holds the PC, requests instruction words from instruction memory over a req/ack handshake, and latches each word into an instruction register. Exposes the decoded fields: imm16 feeds the immediate extender, while rs/rt/rd/opcode/funct feed the register file and control. It also accepts branch/jump redirects from the execute side.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
NOP_WORD, 32'h0000_0000, instruction register content when no valid instruction is held

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
mem_req  output  1  instruction memory request, registered
mem_addr  output  32  word address for request; equals current PC
mem_ack  input  1  memory returns mem_data this cycle
mem_data  input  32  instruction word, valid when mem_ack=1
stall  input  1  consumer cannot accept a new instruction; hold current one
redirect  input  1  change of flow (branch taken / jump)
redirect_pc  input  32  target PC; bits [1:0] ignored, treated as 00
instr_valid  output  1  instr register holds a live instruction
instr  output  32  instruction register
pc_out  output  32  PC of instruction held in instr
pc_plus4  output  32  pc_out + 4 (mod 2^32)
opcode  output  6  instr[31:26]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
shamt  output  5  instr[10:6]
funct  output  6  instr[5:0]
imm16  output  16  instr[15:0], to immediate extender
jaddr  output  26  instr[25:0]

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, mem_req=0, instr_valid=0, instr=NOP_WORD, pc_out=RESET_PC, redirect_pend=0.
- Field outputs are pure slices of instr; pc_plus4 is combinational from pc_out.
- FSM states: IDLE, REQ, HOLD.
- IDLE: next edge -> REQ, mem_req=1, mem_addr=pc.
- REQ: mem_req held 1 and mem_addr stable until mem_ack.
  - On mem_ack with redirect_pend=0: instr<=mem_data, pc_out<=pc, instr_valid<=1, pc<=pc+4, mem_req<=0, go HOLD.
  - On mem_ack with redirect_pend=1: data discarded, instr_valid stays 0, pc<=pend_target, redirect_pend<=0, remain REQ (new request next cycle, mem_req stays 1 with new address).
  - A redirect in REQ sets redirect_pend=1 and pend_target=redirect_pc; the outstanding request is never aborted.
  - If redirect and mem_ack coincide, it is handled as a pending redirect arriving with that ack: data discarded, pc<=redirect_pc.
- HOLD: instr/pc_out stable while stall=1.
  - stall=0: instr_valid<=0, go REQ with mem_addr=pc (sequential), or redirect_pc&~3 if redirect=1 that cycle.
  - Redirect while stall=1: latch pend_target; when stall releases, fetch pend_target.
- Minimum throughput: one instruction per 2 cycles with zero-wait memory (REQ -> ack -> HOLD -> REQ).
- Latency: mem_ack edge -> instr_valid=1 on the same edge (registered capture).
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- mem_ack in IDLE/HOLD: ignored.
- Reset mid-request: handshake is abandoned; memory must tolerate mem_req dropping.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, REQ=2'd1, HOLD=2'd2), field bit positions, INSTR_W=32, NOP_WORD.
- One natural sub-module: instr_field_split (combinational slicing of instr into opcode/rs/rt/rd/shamt/funct/imm16/jaddr), reused by decode.

Test Plan:
- Reset then zero-wait memory returning 32'h2008_0007 at 0x0 -> mem_addr=0x0, instr_valid=1, imm16=16'h0007, rt=8, pc_plus4=0x4; next request at 0x4.
- mem_ack delayed 3 cycles -> mem_req and mem_addr=0x4 held constant for all 3 waiting cycles; instr_valid=0 throughout.
- stall=1 for 4 cycles in HOLD -> instr/pc_out unchanged and mem_req=0; first cycle after release, mem_req=1 with the next PC.
- redirect to 0x0000_0103 during an outstanding REQ at 0x8 -> ack data discarded (instr_valid stays 0); next mem_addr=0x0000_0100.
- RESET_PC=32'hFFFF_FFFC -> after first fetch pc_plus4=0x0000_0000 and next mem_addr=0x0.
- Assert reset while REQ is waiting -> same-time mem_req=0, instr_valid=0, pc=RESET_PC; fetch restarts from IDLE.
